// File: rtl/sram_pingpong_ctrl.sv
// Ping-pong tile SRAM controller: fills one bank from the input stream while draining the other,
// sharing the single SRAM address bus between writes and reads with a round-robin arbiter.
module sram_pingpong_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TILE_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_sel,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [1:0]            bank_full
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TILE_LEN - 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [1:0]            r_full;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic [1:0]            r_fifo_cnt;
  logic                  r_fifo_head;
  logic                  r_rd_pend;
  logic                  r_rd_tag;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic                  r_sel_hold;

  logic   w_wreq;
  logic   w_rreq;
  logic   w_pop;
  logic   w_tail;
  grant_e w_grant;

  // Read credit counts words already buffered plus the one still coming back from the SRAM.
  assign w_wreq = in_valid && !r_full[r_wr_bank];
  assign w_rreq = r_full[r_rd_bank] && ((r_fifo_cnt + {1'b0, r_rd_pend}) < 2'd2);
  assign w_pop  = (r_fifo_cnt != 2'd0) && out_ready;
  assign w_tail = r_fifo_head ^ r_fifo_cnt[0];

  // Arbitration between write and read requests
  always_comb begin
    w_grant = GNT_IDLE;
    if (rst) begin
      w_grant = GNT_IDLE;
    end else if (w_wreq && w_rreq) begin
      w_grant = r_last_grant ? GNT_WR : GNT_RD;
    end else if (w_wreq) begin
      w_grant = GNT_WR;
    end else if (w_rreq) begin
      w_grant = GNT_RD;
    end else begin
      w_grant = GNT_IDLE;
    end
  end

  // SRAM bus drive; an idle cycle keeps the last address and bank on the bus
  always_comb begin
    sram_we   = 1'b0;
    in_ready  = 1'b0;
    sram_addr = r_addr_hold;
    sram_sel  = r_sel_hold;
    case (w_grant)
      GNT_WR: begin
        sram_we   = 1'b1;
        in_ready  = 1'b1;
        sram_addr = r_wr_addr;
        sram_sel  = r_wr_bank;
      end
      GNT_RD: begin
        sram_addr = r_rd_addr;
        sram_sel  = r_rd_bank;
      end
      default: begin
        sram_we = 1'b0;
      end
    endcase
  end

  assign sram_din  = in_data;
  assign out_valid = (r_fifo_cnt != 2'd0);
  assign out_data  = r_fifo_data[r_fifo_head];
  assign out_last  = r_fifo_last[r_fifo_head];
  assign bank_full = r_full;

  // Bank pointers, addresses, full flags and arbiter history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_full       <= 2'b00;
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= 1'b0;
      r_last_grant <= 1'b0;
      r_addr_hold  <= '0;
      r_sel_hold   <= 1'b0;
    end else begin
      r_rd_pend <= (w_grant == GNT_RD);
      if (w_wreq && w_rreq) begin
        r_last_grant <= (w_grant == GNT_RD);
      end
      if (w_grant != GNT_IDLE) begin
        r_addr_hold <= sram_addr;
        r_sel_hold  <= sram_sel;
      end
      case (w_grant)
        GNT_WR: begin
          if (r_wr_addr == LAST_ADDR) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_addr         <= '0;
            r_wr_bank         <= ~r_wr_bank;
          end else begin
            r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
          end
        end
        GNT_RD: begin
          r_rd_tag <= (r_rd_addr == LAST_ADDR);
          // The final read has already sampled the SRAM, so the bank is free for refilling.
          if (r_rd_addr == LAST_ADDR) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_addr         <= '0;
            r_rd_bank         <= ~r_rd_bank;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          r_rd_tag <= r_rd_tag;
        end
      endcase
    end
  end

  // Two-entry output FIFO fed by the returning SRAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_fifo_cnt     <= 2'd0;
      r_fifo_head    <= 1'b0;
    end else begin
      if (r_rd_pend) begin
        r_fifo_data[w_tail] <= sram_dout;
        r_fifo_last[w_tail] <= r_rd_tag;
      end
      if (w_pop) begin
        r_fifo_head <= ~r_fifo_head;
      end
      case ({r_rd_pend, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Bench for sram_pingpong_ctrl: directed scenarios plus random traffic, scored against a
// stream-level model (accepted words reappear in order, tile boundaries marked, bounded bank occupancy).
module tb_sram_pingpong_ctrl;

  localparam int TL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       sram_we;
  logic [7:0] sram_addr;
  logic [7:0] sram_din;
  logic       sram_sel;
  logic [7:0] sram_dout;
  logic [1:0] bank_full;

  sram_pingpong_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TILE_LEN(TL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_sel(sram_sel),
    .sram_dout(sram_dout), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  // Behavioural two-bank SRAM with one-cycle read latency
  logic [7:0] mem [0:1][0:255];
  always @(posedge clk) begin
    if (sram_we) mem[sram_sel][sram_addr] <= sram_din;
    else         sram_dout <= mem[sram_sel][sram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: accepted words in order with their expected tile-end mark
  logic [8:0]  q[$];
  logic [8:0]  olog[$];
  logic [16:0] wlog[$];
  int          acc_cyc[$];
  bit          whist [0:16383];
  int          acc = 0;
  int          tiles_out = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    int pend;
    int pc;
    cyc++;
    whist[cyc % 16384] = sram_we;
    if (rst) begin
      chk("rst_we", sram_we, 0);
      chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("ready_needs_valid", in_ready & ~in_valid, 0);
      chk("we_eq_ready", sram_we, in_ready);
      if (bank_full == 2'b11) chk("both_full_blocks", in_ready, 0);
      pend = acc / TL - tiles_out;
      pc   = $countones(bank_full);
      chk("bank_full_count", (pc == pend) || (pc + 1 == pend), 1);
      if (sram_we) begin
        chk("wr_pos", {23'd0, sram_sel, sram_addr}, (((acc / TL) % 2) << 8) | (acc % TL));
        chk("wr_din", sram_din, in_data);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("out_word", {23'd0, out_last, out_data}, {23'd0, q[0]});
      end
      if (out_valid && out_ready && q.size() > 0) begin
        if (q[0][8]) tiles_out++;
        olog.push_back({out_last, out_data});
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back({(acc % TL) == (TL - 1), in_data});
        wlog.push_back({sram_sel, sram_addr, sram_din});
        acc_cyc.push_back(cyc);
        acc++;
      end
    end
    if (rst) begin
      q.delete();
      acc       = 0;
      tiles_out = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    olog.delete();
    wlog.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int c4;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bank_full", bank_full, 0);
    chk("reset_out_valid", out_valid, 0);
    tick();

    // Fill and drain one tile
    clear_logs();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(i));
    @(negedge clk);
    chk("t1_read_issue", {sram_we, sram_sel, sram_addr}, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("t1_latency", n, 2);
    repeat (10) tick();
    chk("t1_count", olog.size(), 4);
    for (int i = 0; i < 4 && i < olog.size(); i++)
      chk("t1_out", olog[i], {23'd0, (i == 3), 8'(i + 1)});
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("t1_wr", wlog[i], {15'd0, 8'(i), 8'(i + 1)});
    chk("t1_bank_full", bank_full, 0);

    // Ping-pong: two tiles back to back
    reset_pulse();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i));
    repeat (20) tick();
    chk("t2_count", olog.size(), 8);
    for (int i = 0; i < 8 && i < olog.size(); i++)
      chk("t2_out", olog[i], {23'd0, (i == 3 || i == 7), 8'(i + 1)});
    if (wlog.size() == 8) begin
      chk("t2_wr_b0", wlog[3], 17'h00304);
      chk("t2_wr_b1", wlog[4], 17'h10005);
      chk("t2_wr_b1_end", wlog[7], 17'h10308);
    end else chk("t2_wcount", wlog.size(), 8);
    if (acc_cyc.size() >= 4) begin
      c4 = acc_cyc[3];
      for (int k = 1; k <= 6; k++)
        chk("t2_alternate", whist[(c4 + k) % 16384], (k % 2 == 0));
    end

    // Backpressure after a full tile
    reset_pulse();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    repeat (20) tick();
    @(negedge clk);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_data", out_data, 8'd1);
    chk("t3_bank_full", bank_full, 2'b01);
    tick();
    out_ready = 1'b1;
    repeat (15) tick();
    chk("t3_count", olog.size(), 4);
    for (int i = 0; i < 4 && i < olog.size(); i++)
      chk("t3_out", olog[i], {23'd0, (i == 3), 8'(i + 1)});

    // Both banks full
    reset_pulse();
    clear_logs();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    repeat (5) tick();
    in_valid = 1'b1;
    in_data  = 8'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_blocked", in_ready, 0);
      chk("t4_bank_full", bank_full, 2'b11);
    end
    tick();
    out_ready = 1'b1;
    send(8'd9);
    repeat (20) tick();
    if (wlog.size() == 9) chk("t4_ninth_pos", wlog[8], 17'h00009);
    else chk("t4_wcount", wlog.size(), 9);
    chk("t4_count", olog.size(), 8);
    if (olog.size() == 8) begin
      chk("t4_last0", olog[3], 9'h104);
      chk("t4_last1", olog[7], 9'h108);
    end

    // Reset mid-tile
    reset_pulse();
    clear_logs();
    out_ready = 1'b1;
    send(8'h11);
    send(8'h22);
    reset_pulse();
    @(negedge clk);
    chk("t5_bank_full", bank_full, 0);
    chk("t5_out_valid", out_valid, 0);
    tick();
    clear_logs();
    send(8'h55);
    chk("t5_wcount", wlog.size(), 1);
    if (wlog.size() > 0) chk("t5_first_wr", wlog[0], 17'h00055);

    // Idle hold
    reset_pulse();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t6_we", sram_we, 0);
      chk("t6_out_valid", out_valid, 0);
    end
    tick();

    // Random traffic with occasional resets and stall bursts
    reset_pulse();
    for (int blk = 0; blk < 20; blk++) begin
      int stall;
      stall = $urandom_range(0, 3);
      for (int k = 0; k < 200; k++) begin
        in_valid  = ($urandom % 4) != 0;
        in_data   = 8'($urandom);
        out_ready = ($urandom % 4) >= stall;
        rst       = ($urandom % 700) == 0;
        tick();
      end
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) tick();
    chk("drain_remaining", q.size(), acc % TL);
    chk("drain_bank_full", bank_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_pingpong_ctrl.md
Name: sram_pingpong_ctrl

Overview:
- Controller that drives the single-port, two-bank double-buffered tile SRAM from the outside.
- Accepts an input word stream (valid/ready) and fills one bank tile by tile.
- Concurrently drains the other, already-filled bank as an output word stream (valid/ready) toward the systolic-array feeders.
- The SRAM has one shared address bus, so the block time-multiplexes writes and reads cycle by cycle.

Parameters:
- ADDR_WIDTH, 8, SRAM address width.
- DATA_WIDTH, 8, word width.
- TILE_LEN, 16, words per tile; legal range 2..2^ADDR_WIDTH.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_data  input  DATA_WIDTH  input word.
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready.
- out_valid  output  1  output word valid.
- out_data  output  DATA_WIDTH  output word.
- out_last  output  1  marks the final word of a tile; qualified by out_valid.
- out_ready  input  1  downstream accepts the output word.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  ADDR_WIDTH  SRAM address.
- sram_din  output  DATA_WIDTH  SRAM write data; equals in_data.
- sram_sel  output  1  SRAM bank select.
- sram_dout  input  DATA_WIDTH  SRAM read data, valid the cycle after a read is issued.
- bank_full  output  2  per-bank "tile complete, not yet drained" flags.

Behaviour:
- State:
  - wr_bank, rd_bank: 1-bit bank pointers.
  - wr_addr, rd_addr: 0..TILE_LEN-1.
  - full[1:0]: per-bank full flags.
  - 2-entry output FIFO carrying {data, last}.
  - rd_pend: a read was issued last cycle.
  - last_grant: 0 = write, 1 = read.
- Reset:
  - All state is 0; FIFO is empty.
  - out_valid=0, bank_full=0.
  - While rst=1, sram_we=0 and in_ready=0.
- Requests (combinational):
  - wreq = in_valid && !full[wr_bank].
  - rreq = full[rd_bank] && (fifo_count + rd_pend < 2).
- Grant (combinational):
  - Only wreq → write. Only rreq → read.
  - Both → the opposite of last_grant (round-robin). Neither → idle.
  - last_grant updates only on a cycle where both requested.
- Write grant:
  - sram_we=1, sram_sel=wr_bank, sram_addr=wr_addr, in_ready=1.
  - Otherwise in_ready=0. in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Read grant:
  - sram_we=0, sram_sel=rd_bank, sram_addr=rd_addr; rd_pend set next cycle.
  - Tag of the issued read is last = (rd_addr == TILE_LEN-1).
- Idle:
  - sram_we=0; sram_addr/sram_sel hold their previous values.
  - The resulting SRAM dout update is ignored.
- Read data path:
  - When rd_pend=1, push {sram_dout, tag} into the FIFO.
  - Read-issue to out_valid latency is 2 cycles.
  - FIFO head drives out_data/out_last; it pops on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured.
- Write completion:
  - A write at wr_addr==TILE_LEN-1 sets full[wr_bank], wraps wr_addr to 0, and toggles wr_bank.
  - Otherwise wr_addr increments.
- Read issue completion:
  - A read issued at rd_addr==TILE_LEN-1 clears full[rd_bank] in the same edge, wraps rd_addr to 0, and toggles rd_bank.
  - The bank is then immediately writable; the in-flight read has already sampled the SRAM.
- Both banks full: in_ready=0 until a tile's final read is issued.
- Credit limit: at most 2 words are buffered or in flight, so out_ready low never drops or duplicates data.
- Reset mid-tile: all partial tiles and FIFO contents are discarded; after reset, the first accepted input word goes to bank 0, addr 0.
- bank_full = full (registered).

Test Plan:
- Fill and drain: TILE_LEN=4, in stream 1,2,3,4 with out_ready=1 → SRAM writes bank0 addr0..3; then out_data 1,2,3,4 with out_last only on 4; first out_valid exactly 2 cycles after the first read issue.
- Ping-pong: stream 8 words 1..8 continuously with out_ready=1 → bank0 gets 1..4 and bank1 gets 5..8; while bank1 fills, write and read grants alternate; output 1..8 in order, out_last on 4 and 8.
- Backpressure: out_ready=0 after one tile is full → exactly 2 reads issued, then none; raise out_ready → words 1..4 emerge, no loss or duplication.
- Both full: stream 8 words with out_ready=0 → bank_full=2'b11, in_ready=0; the 9th word is accepted only after the read of addr 3 of bank0 is issued.
- Reset mid-tile: accept 2 words, assert rst 1 cycle → bank_full=0, out_valid=0; the next word is written to sel=0, addr=0.
- Idle hold: no in_valid and no full bank → sram_we stays 0 and out_valid stays 0 for 20 cycles.
